// File: rtl/block_sync_lane_pkg.sv
// Shared PCS constants and types for the 66-bit block-lock path.
package block_sync_lane_pkg;

  localparam int unsigned NB_DATA_CODED = 66;
  localparam int unsigned NB_SH         = 2;
  localparam int unsigned NB_OFFSET     = 7;
  localparam int unsigned SH_CNT_MAX    = 64;
  localparam int unsigned SH_INVLD_MAX  = 16;

  localparam int unsigned NB_SH_CNT   = 7;
  localparam int unsigned NB_SH_INVLD = 5;

  localparam logic [NB_SH-1:0] SH_DATA = 2'b01;
  localparam logic [NB_SH-1:0] SH_CTRL = 2'b10;

  // Terminal values in the widths of the registers they are compared against.
  localparam logic [NB_SH_CNT-1:0]   SH_CNT_LAST   = NB_SH_CNT'(SH_CNT_MAX);
  localparam logic [NB_SH_INVLD-1:0] SH_INVLD_LAST = NB_SH_INVLD'(SH_INVLD_MAX);
  localparam logic [NB_OFFSET-1:0]   OFFSET_LAST   = NB_OFFSET'(NB_DATA_CODED - 1);

  typedef enum logic [0:0] {
    TEST_SH = 1'b0,
    SLIP    = 1'b1
  } sync_state_e;

  // A sync header is legal only as a data (01) or control (10) marker.
  function automatic logic sh_is_valid(input logic [NB_SH-1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/block_sync_window.sv
// Combinational bit-window selector: picks Width bits out of {prev, curr} starting
// offset bits below the MSB of prev. Offset 0 returns prev unchanged.
module block_sync_window #(
  parameter int unsigned Width   = 66,
  parameter int unsigned OffsetW = 7
) (
  input  logic [Width-1:0]   prev_word_i,
  input  logic [Width-1:0]   curr_word_i,
  input  logic [OffsetW-1:0] offset_i,
  output logic [Width-1:0]   window_o
);

  logic [2*Width-1:0] shifted;

  // Right shift by (Width - offset) leaves the selected window in the low Width bits.
  always_comb begin
    shifted  = {prev_word_i, curr_word_i} >> (Width - 32'(offset_i));
    window_o = shifted[Width-1:0];
  end

endmodule

// File: rtl/block_sync_lane.sv
// Per-lane 66-bit block lock: searches sync-header alignment by bit slipping, then
// monitors header validity per 64-header window and drops lock after 16 bad headers.
module block_sync_lane
  import block_sync_lane_pkg::*;
(
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_valid,
  input  logic [NB_DATA_CODED-1:0] i_data,
  output logic [NB_DATA_CODED-1:0] o_data,
  output logic                     o_valid,
  output logic                     o_sh_valid,
  output logic                     o_block_lock,
  output logic [NB_OFFSET-1:0]     o_slip_offset
);

  sync_state_e              state_q;
  logic [NB_DATA_CODED-1:0] prev_word_q;
  logic [NB_SH_CNT-1:0]     sh_cnt_q;
  logic [NB_SH_INVLD-1:0]   sh_invld_cnt_q;

  logic                     accept;
  logic                     sh_ok;
  logic [NB_DATA_CODED-1:0] window;
  logic [NB_SH_CNT-1:0]     sh_cnt_inc;
  logic [NB_SH_INVLD-1:0]   sh_invld_inc;

  block_sync_window #(
    .Width   (NB_DATA_CODED),
    .OffsetW (NB_OFFSET)
  ) u_window (
    .prev_word_i (prev_word_q),
    .curr_word_i (i_data),
    .offset_i    (o_slip_offset),
    .window_o    (window)
  );

  // Accept qualifier, header test and the candidate counter values for this word.
  always_comb begin
    accept       = i_valid & i_enable;
    sh_ok        = sh_is_valid(window[NB_DATA_CODED-1 -: NB_SH]);
    sh_cnt_inc   = sh_cnt_q + 1'b1;
    sh_invld_inc = sh_invld_cnt_q + {{(NB_SH_INVLD-1){1'b0}}, ~sh_ok};
  end

  // Lock FSM with registered datapath outputs; i_enable low freezes everything but o_valid.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q        <= TEST_SH;
      prev_word_q    <= '0;
      sh_cnt_q       <= '0;
      sh_invld_cnt_q <= '0;
      o_data         <= '0;
      o_valid        <= 1'b0;
      o_sh_valid     <= 1'b0;
      o_block_lock   <= 1'b0;
      o_slip_offset  <= '0;
    end else begin
      o_valid <= accept;
      if (accept) begin
        prev_word_q <= i_data;
        o_data      <= window;
        o_sh_valid  <= sh_ok;
      end
      if (i_enable) begin
        unique case (state_q)
          TEST_SH: begin
            if (accept) begin
              if (!o_block_lock) begin
                // While searching, any bad header means this offset is wrong.
                if (!sh_ok) begin
                  state_q <= SLIP;
                end else if (sh_cnt_inc == SH_CNT_LAST) begin
                  o_block_lock   <= 1'b1;
                  sh_cnt_q       <= '0;
                  sh_invld_cnt_q <= '0;
                end else begin
                  sh_cnt_q <= sh_cnt_inc;
                end
              end else begin
                // Loss of lock wins over a window that completes on the same header.
                if (sh_invld_inc == SH_INVLD_LAST) begin
                  o_block_lock <= 1'b0;
                  state_q      <= SLIP;
                end else if (sh_cnt_inc == SH_CNT_LAST) begin
                  sh_cnt_q       <= '0;
                  sh_invld_cnt_q <= '0;
                end else begin
                  sh_cnt_q       <= sh_cnt_inc;
                  sh_invld_cnt_q <= sh_invld_inc;
                end
              end
            end
          end
          SLIP: begin
            o_slip_offset  <= (o_slip_offset == OFFSET_LAST) ? '0 : o_slip_offset + 1'b1;
            sh_cnt_q       <= '0;
            sh_invld_cnt_q <= '0;
            o_block_lock   <= 1'b0;
            state_q        <= TEST_SH;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/block_sync_lane.md
Name: block_sync_lane

Overview:
- Per-lane 66-bit block-lock stage on the RX side of the PCS; one instance per lane, 20 in total.
- Consumes the 66-bit-per-lane stream produced by the TX AM-insertion output after the channel. The stream arrives with an unknown bit offset.
- Searches for sync-header alignment by bit slipping and asserts block lock using a Clause-82 style state machine.
- Outputs re-aligned 66-bit blocks to the downstream lane deskew/alignment-marker lock stage.

Parameters:
- NB_DATA_CODED, 66, block width including 2-bit sync header
- NB_SH, 2, sync header width
- NB_OFFSET, 7, width of slip offset (covers 0..65)
- SH_CNT_MAX, 64, sync headers per test window
- SH_INVLD_MAX, 16, invalid headers in one window that cause loss of lock

Ports:
- i_clock  in  1  single clock
- i_reset  in  1  asynchronous, active-low reset
- i_enable  in  1  register-file enable; low freezes all state
- i_valid  in  1  i_data qualifier
- i_data  in  NB_DATA_CODED  raw lane word; bit 65 is first on the wire
- o_data  out  NB_DATA_CODED  aligned block; sync header in [65:64]
- o_valid  out  1  o_data qualifier
- o_sh_valid  out  1  sync header of o_data is 01 or 10
- o_block_lock  out  1  lane locked
- o_slip_offset  out  NB_OFFSET  current bit offset

Behaviour:
- Reset (i_reset=0, async): all outputs 0; prev_word=0; offset=0; sh_cnt=0; sh_invld_cnt=0; state=TEST_SH.
- Accept condition: a word is accepted when i_valid & i_enable.
- On accept:
  - prev_word <= i_data.
  - window = {prev_word, i_data}[131-offset -: 66]. Offset 0 yields prev_word.
- Latency: o_data, o_valid and o_sh_valid are registered, 1 cycle after the accepted word.
- o_valid=0 on every cycle without an accept.
- Sync header is valid iff window[65:64] is 2'b01 or 2'b10.
- States:
  - TEST_SH, on accept:
    - sh_cnt+1; sh_invld_cnt+1 if the header is invalid.
    - Unlocked and header invalid → SLIP.
    - Unlocked and sh_cnt reaches 64 with no invalid header → o_block_lock=1, counters cleared.
    - Locked and sh_invld_cnt reaches 16 → o_block_lock=0, go to SLIP. This takes priority when it coincides with sh_cnt reaching 64.
    - Locked and sh_cnt reaches 64 with sh_invld_cnt<16 → counters cleared, lock held.
  - SLIP (one cycle):
    - offset = (offset==65) ? 0 : offset+1.
    - Counters cleared; o_block_lock=0; → TEST_SH.
    - A word accepted during SLIP updates prev_word and is output with o_valid=1, but is not tested.
- Counter widths: sh_cnt 7 bits, sh_invld_cnt 5 bits. Neither may exceed its max, because both are cleared on reaching it.
- i_enable=0: state, counters, offset and prev_word all hold; o_valid=0; o_block_lock holds.
- Data before lock is still forwarded with o_valid. Downstream qualifies it with o_block_lock.

Decomposition:
- Shared PCS package:
  - SH_DATA=2'b01, SH_CTRL=2'b10.
  - NB_DATA_CODED, SH_CNT_MAX, SH_INVLD_MAX.
  - State encoding constants TEST_SH and SLIP.
- Sub-module block_sync_window: combinational 132→66 bit selector indexed by offset, reusable by the gearbox.
- FSM and counters stay in block_sync_lane.

Test Plan:
1. Aligned stream (offset 0), every header 01, payload 0, continuous valid.
   - o_block_lock rises on the cycle after the 64th tested header; o_slip_offset stays 0.
2. Same stream delayed by 5 bits.
   - Exactly 5 slips; lock after 64 further valid headers; o_slip_offset=5.
   - o_data matches the transmitted blocks.
3. Locked lane, 15 headers forced to 00 within one 64-header window.
   - Lock held; counters clear at 64.
   - Repeat with 16 forced headers: o_block_lock falls on the 16th, and o_slip_offset goes 0→1.
4. Stream misaligned by 65 bits.
   - Offset walks 0..65 and locks at 65.
   - Then force loss of lock: offset wraps to 0.
5. i_enable held low for 10 cycles after 30 tested headers.
   - o_valid=0 and counters frozen during the hold.
   - Lock asserts after 34 more headers.
6. Assert i_reset low asynchronously while locked at offset 5.
   - All outputs 0 immediately; offset=0.
   - Relock completes normally after release.
